// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write bus for the program loader.
// master = field source and memory side, slave = the loader itself.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_class;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, op_class, rs, rt, rd, shamt, funct, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, op_class, rs, rt, rd, shamt, funct, imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into MIPS-lite words and writes them sequentially into
// instruction memory, one word every two cycles, stopping (not wrapping) when memory is full.
module instr_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  instr_encoder_loader_if.slave  bus,
  output logic [ADDR_W:0]        count,
  output logic                   err
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [5:0]        OP_R      = 6'b000000;
  localparam logic [5:0]        OP_LW     = 6'b100011;
  localparam logic [5:0]        OP_SW     = 6'b101011;
  localparam logic [5:0]        OP_BEQ    = 6'b000100;
  localparam logic [5:0]        OP_ORI    = 6'b001101;
  localparam logic [5:0]        FN_SRL    = 6'b000010;
  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  // srl is an R-format word whose rs and funct are fixed, whatever the inputs say.
  function automatic logic [31:0] encode_word(
    input logic [2:0]  cls,
    input logic [4:0]  rs_f,
    input logic [4:0]  rt_f,
    input logic [4:0]  rd_f,
    input logic [4:0]  sh_f,
    input logic [5:0]  fn_f,
    input logic [15:0] imm_f
  );
    logic [31:0] word;
    case (cls)
      3'd0:    word = {OP_R,   rs_f, rt_f, rd_f, sh_f, fn_f};
      3'd1:    word = {OP_LW,  rs_f, rt_f, imm_f};
      3'd2:    word = {OP_SW,  rs_f, rt_f, imm_f};
      3'd3:    word = {OP_BEQ, rs_f, rt_f, imm_f};
      3'd4:    word = {OP_ORI, rs_f, rt_f, imm_f};
      3'd5:    word = {OP_R,   5'd0, rt_f, rd_f, sh_f, FN_SRL};
      default: word = 32'd0;
    endcase
    return word;
  endfunction

  function automatic logic class_legal(input logic [2:0] cls);
    return (cls <= 3'd5);
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              in_ready_s;
  logic              accept_s;

  assign in_ready_s = (state_q == ST_LOAD) & ~clear;
  assign accept_s   = bus.in_valid & in_ready_s;

  // Next-state, address, count and error computation; clear overrides every state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    if (clear) begin
      state_d = ST_LOAD;
      addr_d  = START_A;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept_s && class_legal(bus.op_class)) begin
            wdata_d = encode_word(bus.op_class, bus.rs, bus.rt, bus.rd,
                                  bus.shamt, bus.funct, bus.imm);
            state_d = ST_WRITE;
          end else if (accept_s) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_WRITE: begin
          // The last word parks the address at the top instead of wrapping to zero.
          if (addr_q == ADDR_MAX) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_LOAD;
            addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
          if (count_q == COUNT_MAX) begin
            count_d = count_q;
          end else begin
            count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
          end
        end
        ST_FULL: begin
          state_d = ST_FULL;
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      addr_q  <= START_A;
      count_q <= '0;
      err_q   <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  // A clear arriving during the write cycle cancels the strobe in that same cycle.
  assign bus.imem_we    = (state_q == ST_WRITE) & ~clear;
  assign bus.in_ready   = in_ready_s;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign count          = count_q;
  assign err            = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader: a small memory-fill model predicts every
// strobe, address, encoded word, count, ready and error flag.
module tb_instr_encoder_loader;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [AW:0]   count;
  logic          err;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

  instr_encoder_loader #(.ADDR_W(AW), .START_ADDR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus),
    .count (count),
    .err   (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: where the next word lands, words stored, error seen, memory full.
  int m_addr;
  int m_count;
  int m_err;
  int m_full;
  logic [31:0] cap_wdata;

  int unsigned opc_tab [0:5] = '{32'd0, 32'd35, 32'd43, 32'd4, 32'd13, 32'd0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int cls, input int rs, input int rt,
                                             input int rd, input int sh, input int fn,
                                             input int imm);
    int unsigned w;
    if (cls == 5) begin
      rs = 0;
      fn = 2;
    end
    if (cls == 0 || cls == 5)
      w = (opc_tab[cls] << 26) + (rs << 21) + (rt << 16) + (rd << 11) + (sh << 6) + fn;
    else
      w = (opc_tab[cls] << 26) + (rs << 21) + (rt << 16) + imm;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_addr  = 0;
    m_count = 0;
    m_err   = 0;
    m_full  = 0;
  endtask

  task automatic drive(input int cls, input int rs, input int rt, input int rd,
                       input int sh, input int fn, input int imm);
    bus.in_valid = 1'b1;
    bus.op_class = 3'(cls);
    bus.rs       = 5'(rs);
    bus.rt       = 5'(rt);
    bus.rd       = 5'(rd);
    bus.shamt    = 5'(sh);
    bus.funct    = 6'(fn);
    bus.imm      = 16'(imm);
  endtask

  task automatic do_op(input int cls, input int rs, input int rt, input int rd,
                       input int sh, input int fn, input int imm);
    if (m_full != 0) begin
      chk("full_ready", 32'(bus.in_ready), 32'd0);
      chk("full_count", 32'(count), 32'(DEPTH));
      return;
    end
    chk("ready", 32'(bus.in_ready), 32'd1);
    drive(cls, rs, rt, rd, sh, fn, imm);
    step();
    bus.in_valid = 1'b0;
    if (cls > 5) begin
      m_err = 1;
      chk("ill_we", 32'(bus.imem_we), 32'd0);
      chk("ill_err", 32'(err), 32'(m_err));
      chk("ill_ready", 32'(bus.in_ready), 32'd1);
    end else begin
      chk("we", 32'(bus.imem_we), 32'd1);
      chk("addr", 32'(bus.imem_addr), 32'(m_addr));
      chk("wdata", bus.imem_wdata, model_word(cls, rs, rt, rd, sh, fn, imm));
      chk("ready_in_write", 32'(bus.in_ready), 32'd0);
      cap_wdata = bus.imem_wdata;
      step();
      if (m_count < DEPTH) m_count++;
      if (m_addr == DEPTH - 1) m_full = 1;
      else m_addr++;
      chk("we_off", 32'(bus.imem_we), 32'd0);
      chk("count", 32'(count), 32'(m_count));
      chk("ready_after", 32'(bus.in_ready), 32'(m_full == 0));
      chk("err", 32'(err), 32'(m_err));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("clr_ready", 32'(bus.in_ready), 32'd0);
    chk("clr_we", 32'(bus.imem_we), 32'd0);
    step();
    clear = 1'b0;
    model_reset();
    #1;
    chk("clr_addr", 32'(bus.imem_addr), 32'd0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_ready_after", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // reset state
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    // directed encodings, with literal expected words
    do_op(1, 9, 8, 0, 0, 0, 16'h0004);
    chk("t1_lw", cap_wdata, 32'h8D280004);
    do_op(0, 1, 2, 3, 0, 6'h20, 0);
    chk("t2_r", cap_wdata, 32'h00221820);
    do_op(3, 1, 2, 0, 0, 0, 16'hFFFF);
    chk("t2_beq", cap_wdata, 32'h1022FFFF);
    do_op(7, 3, 3, 3, 3, 3, 3);
    do_op(4, 0, 2, 0, 0, 0, 16'h00FF);
    chk("t3_ori", cap_wdata, 32'h340200FF);
    do_op(5, 7, 5, 4, 3, 6'h3F, 0);
    chk("t3_srl", cap_wdata, 32'h000520C2);
    chk("t4_err_sticky", 32'(err), 32'd1);
    do_clear();

    // clear during the write cycle cancels the strobe
    drive(2, 4, 5, 0, 0, 0, 16'h1234);
    step();
    bus.in_valid = 1'b0;
    chk("cw_we_before", 32'(bus.imem_we), 32'd1);
    do_clear();

    // fill to FULL, then hold valid and confirm nothing more is written
    for (int i = 0; i < DEPTH; i++)
      do_op(int'($urandom_range(0, 5)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 65535)));
    chk("full_count8", 32'(count), 32'(DEPTH));
    drive(1, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_we", 32'(bus.imem_we), 32'd0);
      chk("full_hold_ready", 32'(bus.in_ready), 32'd0);
      chk("full_hold_count", 32'(count), 32'(DEPTH));
    end
    bus.in_valid = 1'b0;
    do_clear();

    // reset asserted in the middle of a write
    do_op(6, 0, 0, 0, 0, 0, 0);
    drive(4, 2, 3, 0, 0, 0, 16'hBEEF);
    step();
    bus.in_valid = 1'b0;
    chk("mrst_we_before", 32'(bus.imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_we", 32'(bus.imem_we), 32'd0);
    step();
    rst_n = 1'b1;
    model_reset();
    step();
    chk("mrst_addr", 32'(bus.imem_addr), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_wdata", bus.imem_wdata, 32'd0);
    chk("mrst_ready", 32'(bus.in_ready), 32'd1);

    // randomized traffic, including illegal classes, clears and repeated fills
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0 || (m_full != 0 && $urandom_range(0, 3) == 0)) begin
        do_clear();
      end else begin
        do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 65535)));
        if ($urandom_range(0, 3) == 0) step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
